// File: rtl/mpu_matrix_loader_if.sv
// Handshake and operand bus between the element stream source and the matrix loader.
// master drives the element stream and start request; slave is the loader.
interface mpu_matrix_loader_if #(
   parameter int DIM   = 5,
   parameter int WIDTH = 8
);
   logic                       start;
   logic [7:0]                 size;
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           in_data;
   logic [DIM*DIM*WIDTH-1:0]   matrix_a;
   logic [DIM*DIM*WIDTH-1:0]   matrix_b;
   logic [7:0]                 mul_size;
   logic                       busy;
   logic                       done;
   logic                       error;

   modport master (
      output start, size, in_valid, in_data,
      input  in_ready, matrix_a, matrix_b, mul_size, busy, done, error
   );

   modport slave (
      input  start, size, in_valid, in_data,
      output in_ready, matrix_a, matrix_b, mul_size, busy, done, error
   );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Packs a row-major signed byte stream into zero-padded 5x5 operands A then B,
// holds them for the multiplier to sweep, then pulses done.
module mpu_matrix_loader #(
   parameter int DIM           = 5,
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 6
) (
   input logic               clock,
   input logic               reset,
   mpu_matrix_loader_if.slave bus
);
   localparam logic [7:0] DIM_B       = 8'(DIM);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, SETTLE, DONE} state_t;

   state_t                   state, state_d;
   logic [7:0]               row, col, cnt, msize;
   logic [DIM*DIM*WIDTH-1:0] mat_a, mat_b;
   logic                     err_q;
   logic                     size_ok, accept, reject, xfer, row_end, last;
   logic                     ready, busy_o, done_o;
   logic [15:0]              elem_off;

   assign size_ok  = (bus.size != 8'd0) && (bus.size <= DIM_B);
   assign row_end  = (col == msize - 8'd1);
   assign last     = row_end && (row == msize - 8'd1);
   assign elem_off = 16'(WIDTH * (DIM * row + col));

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      reject  = 1'b0;
      xfer    = 1'b0;
      ready   = 1'b0;
      done_o  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (size_ok) begin
                  accept  = 1'b1;
                  state_d = LOAD_A;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         LOAD_A: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               xfer = 1'b1;
               if (last) state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               xfer = 1'b1;
               if (last) state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_o = (state != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         mat_a <= '0;
         mat_b <= '0;
         msize <= '0;
         row   <= '0;
         col   <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_d;
         err_q <= reject;
         if (accept) begin
            mat_a <= '0;
            mat_b <= '0;
            msize <= bus.size;
            row   <= '0;
            col   <= '0;
         end
         if (xfer) begin
            if (state == LOAD_A) mat_a[elem_off +: WIDTH] <= bus.in_data;
            else                 mat_b[elem_off +: WIDTH] <= bus.in_data;
            // Last element of an operand rewinds the cursor for the next one.
            if (last) begin
               row <= '0;
               col <= '0;
            end else if (row_end) begin
               col <= '0;
               row <= row + 8'd1;
            end else begin
               col <= col + 8'd1;
            end
         end
         if (state == SETTLE) cnt <= cnt + 8'd1;
         else                 cnt <= '0;
      end
   end

   assign bus.in_ready = ready;
   assign bus.busy     = busy_o;
   assign bus.done     = done_o;
   assign bus.error    = err_q;
   assign bus.matrix_a = mat_a;
   assign bus.matrix_b = mat_b;
   assign bus.mul_size = msize;
endmodule
